// File: rtl/fractal_sync_initiator_if.sv
// Core-side request, tree-side request and wake-up response bundle for one
// fractal sync initiator node.
interface fractal_sync_initiator_if #(
  parameter int LEVEL_WIDTH   = 2,
  parameter int ID_WIDTH      = 2,
  parameter int TIMEOUT_WIDTH = 16
);
  logic                     sync_valid_i;
  logic                     sync_ready_o;
  logic [LEVEL_WIDTH-1:0]   sync_level_i;
  logic [ID_WIDTH-1:0]      sync_id_i;
  logic [TIMEOUT_WIDTH-1:0] timeout_cfg_i;
  logic                     req_valid_o;
  logic                     req_ready_i;
  logic [LEVEL_WIDTH-1:0]   req_level_o;
  logic [ID_WIDTH-1:0]      req_id_o;
  logic                     rsp_valid_i;
  logic [LEVEL_WIDTH-1:0]   rsp_level_i;
  logic [ID_WIDTH-1:0]      rsp_id_i;
  logic                     rsp_error_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;
  logic [1:0]               err_code_o;
  logic                     stray_o;

  modport slave (
    input  sync_valid_i, sync_level_i, sync_id_i, timeout_cfg_i,
    input  req_ready_i, rsp_valid_i, rsp_level_i, rsp_id_i, rsp_error_i,
    output sync_ready_o, req_valid_o, req_level_o, req_id_o,
    output busy_o, done_o, err_o, err_code_o, stray_o
  );

  modport master (
    output sync_valid_i, sync_level_i, sync_id_i, timeout_cfg_i,
    output req_ready_i, rsp_valid_i, rsp_level_i, rsp_id_i, rsp_error_i,
    input  sync_ready_o, req_valid_o, req_level_o, req_id_o,
    input  busy_o, done_o, err_o, err_code_o, stray_o
  );
endinterface

// File: rtl/fractal_sync_initiator.sv
// Per-node fractal sync initiator: issues one barrier request into the tree,
// waits for its wake-up and reports done / error / timeout to the core.
//
// state | meaning
// IDLE  | ready for a core request
// REQ   | request presented to the tree, waiting for req_ready_i
// WAIT  | request handed off, waiting for the matching wake-up
// DONE  | one-cycle success pulse
// ERR   | one-cycle failure pulse, err_code_o valid
module fractal_sync_initiator #(
  parameter int LEVEL_WIDTH   = 2,
  parameter int ID_WIDTH      = 2,
  parameter int N_LEVELS      = 3,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  fractal_sync_initiator_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

  localparam logic [LEVEL_WIDTH-1:0]   MAX_LEVEL = LEVEL_WIDTH'(N_LEVELS);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE   = TIMEOUT_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [LEVEL_WIDTH-1:0]   level_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic [1:0]               code_d, code_q;
  logic                     stray_q;
  logic                     accept, level_bad, rsp_match, expired;

  assign accept    = (state_q == IDLE) && bus.sync_valid_i;
  assign level_bad = (bus.sync_level_i == '0) || (bus.sync_level_i > MAX_LEVEL);
  assign rsp_match = bus.rsp_valid_i && (bus.rsp_level_i == level_q) && (bus.rsp_id_i == id_q);
  assign expired   = (tmo_q != '0) && (cnt_q == tmo_q - CNT_ONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A matching response takes priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    code_d  = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (level_bad) begin
            state_d = ERR;
            code_d  = 2'b01;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ:  if (bus.req_ready_i) state_d = WAIT;
      WAIT: begin
        if (rsp_match) begin
          if (bus.rsp_error_i) begin
            state_d = ERR;
            code_d  = 2'b10;
          end else begin
            state_d = DONE;
          end
        end else if (expired) begin
          state_d = ERR;
          code_d  = 2'b11;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      id_q    <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      code_q  <= 2'b00;
      stray_q <= 1'b0;
    end else begin
      if (accept) begin
        level_q <= bus.sync_level_i;
        id_q    <= bus.sync_id_i;
        tmo_q   <= bus.timeout_cfg_i;
      end
      if ((state_q == REQ) && bus.req_ready_i) begin
        cnt_q <= '0;
      end else if ((state_q == WAIT) && !rsp_match && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      code_q  <= code_d;
      stray_q <= bus.rsp_valid_i && !((state_q == WAIT) && rsp_match);
    end
  end

  assign bus.sync_ready_o = (state_q == IDLE);
  assign bus.req_valid_o  = (state_q == REQ);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);
  assign bus.err_o        = (state_q == ERR);
  assign bus.req_level_o  = level_q;
  assign bus.req_id_o     = id_q;
  assign bus.err_code_o   = code_q;
  assign bus.stray_o      = stray_q;

endmodule

// File: tb/tb_fractal_sync_initiator.sv
// Directed bench for fractal_sync_initiator: cycle-by-cycle comparison against a
// transaction-level model, plus literal latency/count checks per scenario.
module tb_fractal_sync_initiator;
  localparam int LW = 2;
  localparam int IW = 2;
  localparam int NL = 2;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fractal_sync_initiator_if #(.LEVEL_WIDTH(LW), .ID_WIDTH(IW), .TIMEOUT_WIDTH(TW)) bus ();

  fractal_sync_initiator #(
    .LEVEL_WIDTH(LW), .ID_WIDTH(IW), .N_LEVELS(NL), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  // model of the barrier in flight
  int          cyc = 0;
  bit          m_inflight, m_sent, m_stray;
  logic [LW-1:0] m_level;
  logic [IW-1:0] m_id;
  int          m_tmo, m_wait_entry, m_pulse;
  logic [1:0]  m_code;

  // observation counters
  int n_done = 0, n_err = 0, n_hs = 0, n_rv = 0, n_stray = 0;
  int acc_cyc = 0, hs_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [1:0] err_code_seen = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input logic [LW-1:0] l, input logic [IW-1:0] i, input int t);
    bus.sync_valid_i  = 1'b1;
    bus.sync_level_i  = l;
    bus.sync_id_i     = i;
    bus.timeout_cfg_i = TW'(t);
  endtask

  task automatic respond(input logic [LW-1:0] l, input logic [IW-1:0] i, input logic e);
    bus.rsp_valid_i = 1'b1;
    bus.rsp_level_i = l;
    bus.rsp_id_i    = i;
    bus.rsp_error_i = e;
  endtask

  task automatic model_clear();
    m_inflight = 0; m_sent = 0; m_stray = 0; m_pulse = 0;
    m_level = '0; m_id = '0; m_code = 2'b00; m_tmo = 0;
  endtask

  task automatic model_step();
    bit waiting, match;
    waiting = m_inflight && m_sent;
    match   = bus.rsp_valid_i && waiting && bus.rsp_level_i == m_level && bus.rsp_id_i == m_id;
    m_stray = bus.rsp_valid_i && !match;
    if (m_pulse != 0) begin
      m_pulse = 0;
    end else if (!m_inflight) begin
      if (bus.sync_valid_i) begin
        m_level = bus.sync_level_i;
        m_id    = bus.sync_id_i;
        m_tmo   = int'(bus.timeout_cfg_i);
        if (int'(bus.sync_level_i) == 0 || int'(bus.sync_level_i) > NL) begin
          m_pulse = 2; m_code = 2'b01;
        end else begin
          m_inflight = 1; m_sent = 0;
        end
      end
    end else if (!m_sent) begin
      if (bus.req_ready_i) begin
        m_sent = 1; m_wait_entry = cyc;
      end
    end else if (match) begin
      m_inflight = 0;
      m_pulse = bus.rsp_error_i ? 2 : 1;
      m_code  = bus.rsp_error_i ? 2'b10 : 2'b00;
    end else if (m_tmo != 0 && (cyc - 1 - m_wait_entry) == m_tmo - 1) begin
      m_inflight = 0; m_pulse = 2; m_code = 2'b11;
    end
  endtask

  task automatic compare_cycle();
    chk("sync_ready", bus.sync_ready_o, !m_inflight && m_pulse == 0);
    chk("req_valid",  bus.req_valid_o,  m_inflight && !m_sent);
    chk("busy",       bus.busy_o,       m_inflight || m_pulse != 0);
    chk("done",       bus.done_o,       m_pulse == 1);
    chk("err",        bus.err_o,        m_pulse == 2);
    chk("err_code",   bus.err_code_o,   (m_pulse == 2) ? m_code : 2'b00);
    chk("req_level",  bus.req_level_o,  m_level);
    chk("req_id",     bus.req_id_o,     m_id);
    chk("stray",      bus.stray_o,      m_stray);
    if (bus.sync_valid_i && bus.sync_ready_o) acc_cyc = cyc;
    if (bus.req_valid_o) n_rv++;
    if (bus.req_valid_o && bus.req_ready_i) begin n_hs++; hs_cyc = cyc; end
    if (bus.done_o) begin n_done++; done_cyc = cyc; end
    if (bus.err_o) begin n_err++; err_cyc = cyc; err_code_seen = bus.err_code_o; end
    if (bus.stray_o) n_stray++;
  endtask

  initial begin
    int d0, e0, rv0, hs0, s0;
    bus.sync_valid_i = 0; bus.sync_level_i = '0; bus.sync_id_i = '0; bus.timeout_cfg_i = '0;
    bus.req_ready_i = 0; bus.rsp_valid_i = 0; bus.rsp_level_i = '0; bus.rsp_id_i = '0;
    bus.rsp_error_i = 0;
    model_clear();

    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_clear();
        else begin
          cyc++;
          model_step();
        end
      end
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    step(2);
    chk("rst_sync_ready", bus.sync_ready_o, 1);
    chk("rst_req_valid",  bus.req_valid_o, 0);
    chk("rst_busy",       bus.busy_o, 0);
    chk("rst_err_code",   bus.err_code_o, 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // basic barrier: response 2 cycles after the handshake
    d0 = n_done; e0 = n_err; rv0 = n_rv;
    request(2'd2, 2'd1, 0); bus.req_ready_i = 1;
    step(); bus.sync_valid_i = 0;
    step(2); respond(2'd2, 2'd1, 0);
    step(); bus.rsp_valid_i = 0;
    step(2);
    chk("basic_latency", done_cyc - acc_cyc, 4);
    chk("basic_done_cnt", n_done - d0, 1);
    chk("basic_err_cnt", n_err - e0, 0);
    chk("basic_rv_cycles", n_rv - rv0, 1);
    chk("basic_ready_back", bus.sync_ready_o, 1);

    // minimum latency
    request(2'd1, 2'd3, 0);
    step(); bus.sync_valid_i = 0;
    step(); respond(2'd1, 2'd3, 0);
    step(); bus.rsp_valid_i = 0;
    step(2);
    chk("min_latency", done_cyc - acc_cyc, 3);

    // backpressure
    d0 = n_done; rv0 = n_rv; hs0 = n_hs;
    request(2'd2, 2'd2, 0); bus.req_ready_i = 0;
    step(); bus.sync_valid_i = 0;
    step(5); bus.req_ready_i = 1;
    step(); respond(2'd2, 2'd2, 0);
    step(); bus.rsp_valid_i = 0;
    step(2);
    chk("bp_rv_cycles", n_rv - rv0, 6);
    chk("bp_handshakes", n_hs - hs0, 1);
    chk("bp_done_cnt", n_done - d0, 1);

    // illegal levels
    rv0 = n_rv; e0 = n_err;
    request(2'd0, 2'd1, 0);
    step(); bus.sync_valid_i = 0;
    step(2);
    chk("ill0_latency", err_cyc - acc_cyc, 1);
    chk("ill0_code", err_code_seen, 1);
    request(2'd3, 2'd2, 0);
    step(); bus.sync_valid_i = 0;
    step(2);
    chk("ill3_latency", err_cyc - acc_cyc, 1);
    chk("ill3_code", err_code_seen, 1);
    chk("ill_rv_cycles", n_rv - rv0, 0);
    chk("ill_err_cnt", n_err - e0, 2);

    // stray while idle
    s0 = n_stray;
    respond(2'd1, 2'd1, 0);
    step(); bus.rsp_valid_i = 0;
    step(2);
    chk("idle_stray_cnt", n_stray - s0, 1);

    // stray in handshake cycle, wrong id, then remote error
    s0 = n_stray; d0 = n_done;
    request(2'd1, 2'd2, 0);
    step(); bus.sync_valid_i = 0; respond(2'd1, 2'd2, 0);
    step(); respond(2'd1, 2'd1, 0);
    step(); respond(2'd1, 2'd2, 1);
    step(); bus.rsp_valid_i = 0; bus.rsp_error_i = 0;
    step(2);
    chk("rem_stray_cnt", n_stray - s0, 2);
    chk("rem_latency", err_cyc - acc_cyc, 4);
    chk("rem_code", err_code_seen, 2);
    chk("rem_done_cnt", n_done - d0, 0);

    // timeout; cfg change after accept must not matter
    d0 = n_done;
    request(2'd2, 2'd3, 4);
    step(); bus.sync_valid_i = 0; bus.timeout_cfg_i = TW'(1);
    step(6);
    chk("tmo_latency", err_cyc - (hs_cyc + 1), 4);
    chk("tmo_code", err_code_seen, 3);
    chk("tmo_done_cnt", n_done - d0, 0);
    step(1);

    // matching response on the expiry cycle wins
    e0 = n_err;
    request(2'd2, 2'd3, 4);
    step(); bus.sync_valid_i = 0;
    step(4); respond(2'd2, 2'd3, 0);
    step(); bus.rsp_valid_i = 0;
    step(2);
    chk("tmo_race_latency", done_cyc - (hs_cyc + 1), 4);
    chk("tmo_race_err_cnt", n_err - e0, 0);

    // reset while waiting
    request(2'd1, 2'd1, 3);
    step(); bus.sync_valid_i = 0;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.sync_ready_o, 1);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_req_level", bus.req_level_o, 0);
    chk("mid_rst_req_id", bus.req_id_o, 0);
    d0 = n_done; e0 = n_err;
    respond(2'd1, 2'd1, 0);
    step(2);
    bus.rsp_valid_i = 0;
    rst_n = 1'b1;
    step(6);
    chk("post_rst_done_cnt", n_done - d0, 0);
    chk("post_rst_err_cnt", n_err - e0, 0);

    request(2'd2, 2'd0, 0);
    step(); bus.sync_valid_i = 0;
    step(2); respond(2'd2, 2'd0, 0);
    step(); bus.rsp_valid_i = 0;
    step(2);
    chk("post_rst_latency", done_cyc - acc_cyc, 4);
    chk("post_rst_done", n_done - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
